bus_master: RTL
===============

BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 Parameter TIMEOUT, default 64, max cycles waited in WAIT for slave ready before abort.
REQ-002 Parameter HOLD, default 2, cycles each operand-write phase is held on the bus (minimum 2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  requester offers operand pair.
REQ-006 cmd_ready  output  1  block can accept a command (high only in IDLE).
REQ-007 op_a  input  32  first operand, sampled on cmd_valid&&cmd_ready.
REQ-008 op_b  input  32  second operand, sampled on cmd_valid&&cmd_ready.
REQ-009 valid  output  1  bus transaction active toward downstream slave.
REQ-010 start  output  1  request multiply result from slave.
REQ-011 address  output  32  slave register select: 1=operand A, 2=operand B, 0=result.
REQ-012 register_data  output  32  write data toward slave.
REQ-013 ready  input  1  slave result valid on result_data.
REQ-014 result_data  input  32  product from slave.
REQ-015 rsp_valid  output  1  response available.
REQ-016 rsp_ready  input  1  requester accepts response.
REQ-017 rsp_data  output  32  captured product (0 on error).
REQ-018 rsp_err  output  1  response is a timeout abort.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states IDLE, WR_A, WR_B, REQ, WAIT, RESP; one-hot or binary is implementer's choice.
REQ-021 IDLE: cmd_ready=1; on cmd_valid latch op_a/op_b into internal registers, go WR_A next cycle.
REQ-022 WR_A: valid=1, start=0, address=1, register_data=latched op_a, held exactly HOLD cycles, then WR_B.
REQ-023 WR_B: valid=1, start=0, address=2, register_data=latched op_b, held exactly HOLD cycles, then REQ.
REQ-024 REQ: valid=1, start=1, address=0, register_data=0 for one cycle; timeout counter cleared; go WAIT.
REQ-025 WAIT: valid=1, start=1, address=0 held; counter increments each cycle.
REQ-026 WAIT, ready=1 sampled: capture result_data into rsp_data, rsp_err=0, go RESP; ready wins over timeout when both occur same cycle.
REQ-027 WAIT, counter reaches TIMEOUT-1 with ready=0: rsp_data=0, rsp_err=1, go RESP.
REQ-028 RESP: valid=0, start=0, address=0, rsp_valid=1; rsp_data/rsp_err stable until rsp_valid&&rsp_ready, then IDLE.
REQ-029 ready asserted outside WAIT is ignored; no state change, no capture.
REQ-030 cmd_valid outside IDLE is ignored; operands are not re-sampled mid-operation.
REQ-031 Latency, no stalls, HOLD=2, slave ready on first WAIT cycle: cmd handshake at cycle 0, rsp_valid at cycle 7.
REQ-032 Back-to-back commands: rsp handshake cycle returns to IDLE; next command accepted earliest one cycle later.
REQ-033 All outputs are registered or decoded from registered state only; no combinational path from ready or cmd_valid to any output.
REQ-034 Operands and result pass unmodified; no arithmetic or width conversion in this block.

Reset
REQ-035 rst_n low forces IDLE immediately, asynchronously, including mid-operation.
REQ-036 Reset values: cmd_ready=1 only after rst_n deasserts (0 while asserted), valid=0, start=0, address=0, register_data=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
REQ-037 Latched operands and timeout counter clear to 0 on reset.

Verification
REQ-038 op_a=6, op_b=7, slave ready with result_data=42 two cycles into WAIT -> address sequence 1,1,2,2,0...; rsp_valid with rsp_data=42, rsp_err=0.
REQ-039 op_a=32'hFFFF_FFFF, op_b=2, ready never asserted -> after TIMEOUT WAIT cycles rsp_valid=1, rsp_err=1, rsp_data=0.
REQ-040 ready and timeout expiry in same cycle, result_data=5 -> rsp_data=5, rsp_err=0.
REQ-041 rst_n pulsed low during WR_B -> valid/start drop same cycle, block in IDLE with cmd_ready=1 after release; no rsp_valid.
REQ-042 rsp_ready held low 10 cycles in RESP -> rsp_valid and rsp_data stable throughout; new cmd_valid ignored until IDLE.
REQ-043 Spurious ready=1 during WR_A -> no capture, sequence continues normally to correct result.

Source files
------------

// File: rtl/bus_master.sv
// bus_master: turns one operand-pair command into a register-write sequence
// toward a multiply slave (A, then B, then result request). It waits a bounded
// number of cycles for the slave's ready and returns the product, or an error
// response on timeout. All outputs are registered.
module bus_master #(
  parameter int TIMEOUT = 64,
  parameter int HOLD    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        valid,
  output logic        start,
  output logic [31:0] address,
  output logic [31:0] register_data,
  input  logic        ready,
  input  logic [31:0] result_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_A,
    S_WR_B,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  // Counter widths sized so TIMEOUT-1 and HOLD-1 are always representable.
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  localparam logic [31:0] ADDR_RESULT = 32'd0;
  localparam logic [31:0] ADDR_OP_A   = 32'd1;
  localparam logic [31:0] ADDR_OP_B   = 32'd2;

  state_t        state;
  logic [31:0]   op_a_q;
  logic [31:0]   op_b_q;
  logic [TW-1:0] wait_cnt;
  logic [HW-1:0] hold_cnt;

  // Single FSM: every output is loaded on the edge that enters a state, so the
  // bus and response signals are pure flops with no path from ready/cmd_valid.
  // cmd_ready resets low and rises on the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      wait_cnt      <= '0;
      hold_cnt      <= '0;
      cmd_ready     <= 1'b0;
      valid         <= 1'b0;
      start         <= 1'b0;
      address       <= '0;
      register_data <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_ready && cmd_valid) begin
            op_a_q        <= op_a;
            op_b_q        <= op_b;
            hold_cnt      <= '0;
            cmd_ready     <= 1'b0;
            busy          <= 1'b1;
            valid         <= 1'b1;
            start         <= 1'b0;
            address       <= ADDR_OP_A;
            register_data <= op_a;
            state         <= S_WR_A;
          end
        end

        S_WR_A: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt      <= '0;
            address       <= ADDR_OP_B;
            register_data <= op_b_q;
            state         <= S_WR_B;
          end else begin
            hold_cnt      <= hold_cnt + 1'b1;
            register_data <= op_a_q;
          end
        end

        S_WR_B: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt      <= '0;
            wait_cnt      <= '0;
            start         <= 1'b1;
            address       <= ADDR_RESULT;
            register_data <= '0;
            state         <= S_REQ;
          end else begin
            hold_cnt      <= hold_cnt + 1'b1;
          end
        end

        S_REQ: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (ready) begin
            rsp_data  <= result_data;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            valid     <= 1'b0;
            start     <= 1'b0;
            state     <= S_RESP;
          end else if (wait_cnt == TO_LAST) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            valid     <= 1'b0;
            start     <= 1'b0;
            state     <= S_RESP;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          valid     <= 1'b0;
          start     <= 1'b0;
          address   <= '0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
